// File: rtl/alu_writeback_stage.sv
// -----------------------------------------------------------------------------
// alu_writeback_stage
//
// Execute/writeback stage sitting directly behind the 8-bit ALU. It accepts one
// instruction per cycle while idle, writes ALU results back to the register
// file, performs the data-memory transaction for load/store, and owns the
// architectural overflow flag that feeds the ALU OverflowIn.
//
// Ports
//   Clk, ResetN      clock (rising edge) and asynchronous active-low reset
//   InValid/InReady  instruction handshake from decode (accept = both high)
//   OpIn             ALU opcode for the presented instruction
//   AluOut           ALU result (also the memory address for load/store)
//   AluOverflow      ALU overflow for add/sub
//   StoreData        write data for store
//   DestReg          destination register index
//   OverflowFlag     architectural overflow flag
//   MemReq/MemWrite  memory request and direction, held until ack or timeout
//   MemAddr/MemWData memory address and write data, stable while MemReq
//   MemRData/MemAck  memory read data and completion strobe
//   RegWrite         one-cycle register-file write strobe
//   RegWAddr/RegWData register-file write index and data (hold when idle)
//   Halted           sticky, set by halt
//   MemError         sticky, set by a memory timeout
// -----------------------------------------------------------------------------
module alu_writeback_stage #(
    parameter int unsigned REG_ADDR_W  = 3,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [3:0]            OpIn,
    input  logic [7:0]            AluOut,
    input  logic                  AluOverflow,
    input  logic [7:0]            StoreData,
    input  logic [REG_ADDR_W-1:0] DestReg,
    output logic                  OverflowFlag,
    output logic                  MemReq,
    output logic                  MemWrite,
    output logic [7:0]            MemAddr,
    output logic [7:0]            MemWData,
    input  logic [7:0]            MemRData,
    input  logic                  MemAck,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] RegWAddr,
    output logic [7:0]            RegWData,
    output logic                  Halted,
    output logic                  MemError
);

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpLoad  = 4'b0010;
    localparam logic [3:0] OpStore = 4'b0011;
    localparam logic [3:0] OpRst   = 4'b1010;
    localparam logic [3:0] OpHalt  = 4'b1011;

    localparam logic [7:0] TimeoutLimit = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StMemWait,
        StHalted
    } stateT;

    stateT                 stateQ, stateD;
    logic [7:0]            timeoutCntQ, timeoutCntD;
    logic [7:0]            timeoutCntInc;
    logic                  overflowFlagQ, overflowFlagD;
    logic                  haltedQ, haltedD;
    logic                  memErrorQ, memErrorD;
    logic                  memReqQ, memReqD;
    logic                  memWriteQ, memWriteD;
    logic [7:0]            memAddrQ, memAddrD;
    logic [7:0]            memWDataQ, memWDataD;
    logic [REG_ADDR_W-1:0] pendDestQ, pendDestD;
    logic                  regWriteQ, regWriteD;
    logic [REG_ADDR_W-1:0] regWAddrQ, regWAddrD;
    logic [7:0]            regWDataQ, regWDataD;
    logic                  accept;

    // Qualified with ResetN so decode never sees a ready stage while reset is held.
    assign InReady = (stateQ == StIdle) && ResetN;
    assign accept  = InValid && InReady;

    assign timeoutCntInc = timeoutCntQ + 8'd1;

    always_comb begin
        stateD        = stateQ;
        timeoutCntD   = timeoutCntQ;
        overflowFlagD = overflowFlagQ;
        haltedD       = haltedQ;
        memErrorD     = memErrorQ;
        memReqD       = memReqQ;
        memWriteD     = memWriteQ;
        memAddrD      = memAddrQ;
        memWDataD     = memWDataQ;
        pendDestD     = pendDestQ;
        regWriteD     = 1'b0;
        regWAddrD     = regWAddrQ;
        regWDataD     = regWDataQ;

        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    case (OpIn)
                        OpAdd, OpSub: begin
                            regWriteD     = 1'b1;
                            regWAddrD     = DestReg;
                            regWDataD     = AluOut;
                            overflowFlagD = AluOverflow;
                        end
                        OpLoad, OpStore: begin
                            stateD      = StMemWait;
                            timeoutCntD = 8'd0;
                            memReqD     = 1'b1;
                            memWriteD   = (OpIn == OpStore);
                            memAddrD    = AluOut;
                            memWDataD   = StoreData;
                            pendDestD   = DestReg;
                        end
                        OpRst: begin
                            overflowFlagD = 1'b0;
                        end
                        OpHalt: begin
                            haltedD = 1'b1;
                            stateD  = StHalted;
                        end
                        default: begin
                            // Remaining ALU operations write back without touching the flag.
                            regWriteD = 1'b1;
                            regWAddrD = DestReg;
                            regWDataD = AluOut;
                        end
                    endcase
                end
            end

            StMemWait: begin
                if (MemAck) begin
                    // An ack on the same edge the limit is reached still completes.
                    stateD      = StIdle;
                    timeoutCntD = 8'd0;
                    memReqD     = 1'b0;
                    if (!memWriteQ) begin
                        regWriteD = 1'b1;
                        regWAddrD = pendDestQ;
                        regWDataD = MemRData;
                    end
                end else if (timeoutCntInc == TimeoutLimit) begin
                    stateD      = StIdle;
                    timeoutCntD = 8'd0;
                    memReqD     = 1'b0;
                    memErrorD   = 1'b1;
                end else begin
                    timeoutCntD = timeoutCntInc;
                end
            end

            StHalted: begin
                // Absorbing until reset.
            end

            default: begin
                stateD  = StIdle;
                memReqD = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            stateQ        <= StIdle;
            timeoutCntQ   <= 8'd0;
            overflowFlagQ <= 1'b0;
            haltedQ       <= 1'b0;
            memErrorQ     <= 1'b0;
            memReqQ       <= 1'b0;
            memWriteQ     <= 1'b0;
            memAddrQ      <= 8'd0;
            memWDataQ     <= 8'd0;
            pendDestQ     <= '0;
            regWriteQ     <= 1'b0;
            regWAddrQ     <= '0;
            regWDataQ     <= 8'd0;
        end else begin
            stateQ        <= stateD;
            timeoutCntQ   <= timeoutCntD;
            overflowFlagQ <= overflowFlagD;
            haltedQ       <= haltedD;
            memErrorQ     <= memErrorD;
            memReqQ       <= memReqD;
            memWriteQ     <= memWriteD;
            memAddrQ      <= memAddrD;
            memWDataQ     <= memWDataD;
            pendDestQ     <= pendDestD;
            regWriteQ     <= regWriteD;
            regWAddrQ     <= regWAddrD;
            regWDataQ     <= regWDataD;
        end
    end

    assign OverflowFlag = overflowFlagQ;
    assign Halted       = haltedQ;
    assign MemError     = memErrorQ;
    assign MemReq       = memReqQ;
    assign MemWrite     = memWriteQ;
    assign MemAddr      = memAddrQ;
    assign MemWData     = memWDataQ;
    assign RegWrite     = regWriteQ;
    assign RegWAddr     = regWAddrQ;
    assign RegWData     = regWDataQ;

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;

    localparam int AW = 3;
    localparam int TO = 4;

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpLoad  = 4'b0010;
    localparam logic [3:0] OpStore = 4'b0011;
    localparam logic [3:0] OpOr    = 4'b0111;
    localparam logic [3:0] OpRst   = 4'b1010;
    localparam logic [3:0] OpHalt  = 4'b1011;

    logic          Clk = 1'b0;
    logic          ResetN = 1'b1;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [3:0]    OpIn = 4'd0;
    logic [7:0]    AluOut = 8'd0;
    logic          AluOverflow = 1'b0;
    logic [7:0]    StoreData = 8'd0;
    logic [AW-1:0] DestReg = '0;
    logic          OverflowFlag;
    logic          MemReq;
    logic          MemWrite;
    logic [7:0]    MemAddr;
    logic [7:0]    MemWData;
    logic [7:0]    MemRData = 8'd0;
    logic          MemAck = 1'b0;
    logic          RegWrite;
    logic [AW-1:0] RegWAddr;
    logic [7:0]    RegWData;
    logic          Halted;
    logic          MemError;

    int nChecks = 0;
    int nFail   = 0;

    alu_writeback_stage #(
        .REG_ADDR_W (AW),
        .MEM_TIMEOUT(TO)
    ) dut (
        .Clk         (Clk),
        .ResetN      (ResetN),
        .InValid     (InValid),
        .InReady     (InReady),
        .OpIn        (OpIn),
        .AluOut      (AluOut),
        .AluOverflow (AluOverflow),
        .StoreData   (StoreData),
        .DestReg     (DestReg),
        .OverflowFlag(OverflowFlag),
        .MemReq      (MemReq),
        .MemWrite    (MemWrite),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemRData    (MemRData),
        .MemAck      (MemAck),
        .RegWrite    (RegWrite),
        .RegWAddr    (RegWAddr),
        .RegWData    (RegWData),
        .Halted      (Halted),
        .MemError    (MemError)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: an instruction either finishes immediately, or opens
    // one outstanding memory transaction that ends on ack or after TO cycles.
    // ---------------------------------------------------------------------
    bit            mBusy = 0;
    bit            mIsLoad = 0;
    logic [7:0]    mAddr = 0;
    logic [7:0]    mWData = 0;
    logic [AW-1:0] mDest = 0;
    int            mAge = 0;
    bit            mFlag = 0;
    bit            mHalted = 0;
    bit            mErr = 0;
    bit            mRegWrite = 0;
    logic [AW-1:0] mRegWAddr = 0;
    logic [7:0]    mRegWData = 0;

    always @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            mBusy <= 0; mIsLoad <= 0; mAddr <= 0; mWData <= 0; mDest <= 0; mAge <= 0;
            mFlag <= 0; mHalted <= 0; mErr <= 0;
            mRegWrite <= 0; mRegWAddr <= 0; mRegWData <= 0;
        end else begin
            mRegWrite <= 0;
            if (mHalted) begin
                // nothing happens until reset
            end else if (mBusy) begin
                if (MemAck) begin
                    mBusy <= 0;
                    mAge  <= 0;
                    if (mIsLoad) begin
                        mRegWrite <= 1; mRegWAddr <= mDest; mRegWData <= MemRData;
                    end
                end else if (mAge + 1 == TO) begin
                    mBusy <= 0; mAge <= 0; mErr <= 1;
                end else begin
                    mAge <= mAge + 1;
                end
            end else if (InValid) begin
                if (OpIn == OpAdd || OpIn == OpSub) begin
                    mRegWrite <= 1; mRegWAddr <= DestReg; mRegWData <= AluOut;
                    mFlag <= AluOverflow;
                end else if (OpIn == OpLoad || OpIn == OpStore) begin
                    mBusy <= 1; mIsLoad <= (OpIn == OpLoad); mAge <= 0;
                    mAddr <= AluOut; mWData <= StoreData; mDest <= DestReg;
                end else if (OpIn == OpRst) begin
                    mFlag <= 0;
                end else if (OpIn == OpHalt) begin
                    mHalted <= 1;
                end else begin
                    mRegWrite <= 1; mRegWAddr <= DestReg; mRegWData <= AluOut;
                end
            end
        end
    end

    always @(negedge Clk) begin
        check("cmp_inready", InReady, ResetN && !mBusy && !mHalted);
        check("cmp_flag", OverflowFlag, mFlag);
        check("cmp_halted", Halted, mHalted);
        check("cmp_memerror", MemError, mErr);
        check("cmp_memreq", MemReq, mBusy);
        check("cmp_regwrite", RegWrite, mRegWrite);
        check("cmp_regwaddr", RegWAddr, mRegWAddr);
        check("cmp_regwdata", RegWData, mRegWData);
        if (mBusy) begin
            check("cmp_memwrite", MemWrite, !mIsLoad);
            check("cmp_memaddr", MemAddr, mAddr);
            if (!mIsLoad) check("cmp_memwdata", MemWData, mWData);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] alu, input logic ovf,
                         input logic [7:0] sd, input logic [AW-1:0] dst);
        InValid = 1; OpIn = op; AluOut = alu; AluOverflow = ovf; StoreData = sd; DestReg = dst;
    endtask

    task automatic idle();
        InValid = 0;
    endtask

    int reqCycles;

    initial begin
        #2 ResetN = 0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_inready", InReady, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_flag", OverflowFlag, 0);
        check("rst_memreq", MemReq, 0);
        check("rst_halted", Halted, 0);
        ResetN = 1;
        #1 check("ready_after_rst", InReady, 1);

        // add with overflow
        drive(OpAdd, 8'hF0, 1, 8'h00, 3'd2);
        tick(); idle();
        check("add_regwrite", RegWrite, 1);
        check("add_wdata", RegWData, 8'hF0);
        check("add_waddr", RegWAddr, 2);
        check("add_flag", OverflowFlag, 1);

        // back-to-back sub then or
        drive(OpSub, 8'h11, 0, 8'h00, 3'd3);
        tick();
        check("b2b_ready", InReady, 1);
        drive(OpOr, 8'h77, 1, 8'h00, 3'd4);
        check("sub_regwrite", RegWrite, 1);
        check("sub_wdata", RegWData, 8'h11);
        check("sub_waddr", RegWAddr, 3);
        check("sub_flag", OverflowFlag, 0);
        tick(); idle();
        check("or_regwrite", RegWrite, 1);
        check("or_wdata", RegWData, 8'h77);
        check("or_waddr", RegWAddr, 4);
        check("or_flag_held", OverflowFlag, 0);
        tick();
        check("pulse_end", RegWrite, 0);
        check("wdata_hold", RegWData, 8'h77);

        // load with ack on the third wait edge; an add is offered meanwhile and must be ignored
        drive(OpLoad, 8'h40, 0, 8'h00, 3'd5);
        tick();
        drive(OpAdd, 8'h99, 1, 8'h00, 3'd6);
        reqCycles = 0;
        check("load_memwrite", MemWrite, 0);
        check("load_addr", MemAddr, 8'h40);
        check("load_ready", InReady, 0);
        if (MemReq) reqCycles++;
        tick();
        if (MemReq) reqCycles++;
        check("load_ready_wait", InReady, 0);
        tick();
        if (MemReq) reqCycles++;
        idle();
        MemAck = 1; MemRData = 8'h5A;
        tick();
        MemAck = 0;
        check("load_req_cycles", reqCycles, 3);
        check("load_req_drop", MemReq, 0);
        check("load_regwrite", RegWrite, 1);
        check("load_wdata", RegWData, 8'h5A);
        check("load_waddr", RegWAddr, 5);
        check("load_flag_kept", OverflowFlag, 0);
        check("load_ready_back", InReady, 1);

        // stray ack while idle
        MemAck = 1; MemRData = 8'hEE;
        tick();
        MemAck = 0;
        check("stray_ack_regwrite", RegWrite, 0);
        check("stray_ack_memreq", MemReq, 0);

        // store that times out
        drive(OpStore, 8'h80, 0, 8'hC3, 3'd1);
        tick(); idle();
        check("store_memwrite", MemWrite, 1);
        check("store_wdata", MemWData, 8'hC3);
        check("store_addr", MemAddr, 8'h80);
        reqCycles = 0;
        for (int i = 0; i < 20 && MemReq; i++) begin
            reqCycles++;
            tick();
        end
        check("store_req_cycles", reqCycles, TO);
        check("store_memerror", MemError, 1);
        check("store_no_regwrite", RegWrite, 0);
        check("store_ready_back", InReady, 1);

        // ack arriving on the edge the limit is reached wins
        drive(OpLoad, 8'h33, 0, 8'h00, 3'd7);
        tick(); idle();
        tick(); tick(); tick();
        MemAck = 1; MemRData = 8'hA5;
        tick();
        MemAck = 0;
        check("edge_ack_regwrite", RegWrite, 1);
        check("edge_ack_wdata", RegWData, 8'hA5);
        check("edge_ack_waddr", RegWAddr, 7);
        check("edge_ack_memreq", MemReq, 0);

        // flag set, rst clears it, halt freezes the stage
        drive(OpAdd, 8'h01, 1, 8'h00, 3'd0);
        tick(); idle();
        check("flag_set", OverflowFlag, 1);
        drive(OpRst, 8'h55, 0, 8'h00, 3'd1);
        tick(); idle();
        check("rst_op_flag", OverflowFlag, 0);
        check("rst_op_noreg", RegWrite, 0);
        drive(OpHalt, 8'h00, 0, 8'h00, 3'd0);
        tick();
        check("halt_halted", Halted, 1);
        check("halt_ready", InReady, 0);
        drive(OpAdd, 8'h12, 1, 8'h00, 3'd2);
        repeat (3) tick();
        idle();
        check("halt_noreg", RegWrite, 0);
        check("halt_flag", OverflowFlag, 0);
        check("halt_wdata_hold", RegWData, 8'h01);
        check("halt_sticky", Halted, 1);

        // reset clears halt, then reset asserted in the middle of a load
        ResetN = 0;
        tick();
        ResetN = 1;
        #1;
        check("rerst_halted", Halted, 0);
        check("rerst_memerror", MemError, 0);
        check("rerst_ready", InReady, 1);
        drive(OpLoad, 8'h22, 0, 8'h00, 3'd3);
        tick(); idle();
        check("midrst_req_before", MemReq, 1);
        ResetN = 0;
        #1;
        check("midrst_memreq", MemReq, 0);
        check("midrst_regwrite", RegWrite, 0);
        check("midrst_ready", InReady, 0);
        check("midrst_addr", MemAddr, 0);
        check("midrst_wdata", RegWData, 0);
        MemAck = 1; MemRData = 8'hBB;
        tick(); tick();
        MemAck = 0;
        ResetN = 1;
        tick();
        check("post_rst_ready", InReady, 1);
        check("post_rst_regwrite", RegWrite, 0);
        check("post_rst_memreq", MemReq, 0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Execute/writeback stage directly downstream of the 8-bit ALU.
- Captures the ALU result, overflow and opcode.
- Performs the data-memory transaction for load/store.
- Drives the register-file write port and owns the architectural overflow flag, which feeds the ALU OverflowIn.
- Handles rst (clear flag) and halt (stop accepting instructions).

Parameters:
- REG_ADDR_W, 3: width of the destination register index.
- MEM_TIMEOUT, 255: max cycles in MEM_WAIT before abort; legal range 1..255.

Ports:
- Clk  input  1  single clock, rising edge
- ResetN  input  1  asynchronous, active-low reset
- InValid  input  1  decode presents a valid instruction this cycle
- InReady  output  1  stage can accept an instruction this cycle
- OpIn  input  4  ALU opcode, same encoding as the ALU
- AluOut  input  8  ALU Out for this instruction
- AluOverflow  input  1  ALU OverflowOut for this instruction
- StoreData  input  8  data to write for store
- DestReg  input  REG_ADDR_W  destination register index
- OverflowFlag  output  1  architectural overflow flag, wired to ALU OverflowIn
- MemReq  output  1  memory request, held until ack or timeout
- MemWrite  output  1  1 = write, 0 = read; valid while MemReq
- MemAddr  output  8  memory address (AluOut captured at accept)
- MemWData  output  8  write data (StoreData captured at accept)
- MemRData  input  8  read data, valid when MemAck
- MemAck  input  1  memory completes the request this cycle
- RegWrite  output  1  one-cycle register-file write strobe
- RegWAddr  output  REG_ADDR_W  write index
- RegWData  output  8  write data
- Halted  output  1  sticky; halt executed
- MemError  output  1  sticky; memory timeout occurred

Behaviour:
- Reset (ResetN low, async): all outputs 0, including OverflowFlag, Halted and MemError; state IDLE; timeout counter 0.
  - Reset asserted mid-MEM_WAIT aborts the transaction: MemReq drops immediately and no RegWrite is issued.
- States: IDLE, MEM_WAIT, HALTED.
- InReady = 1 only in IDLE with ResetN high. This is a combinational decode of the state.
- Accept occurs when InValid & InReady at a rising edge. The stage captures OpIn, AluOut, AluOverflow, StoreData and DestReg.
- add (0000), sub (0001):
  - Next cycle: RegWrite = 1, RegWData = AluOut, RegWAddr = DestReg.
  - OverflowFlag <= AluOverflow.
  - Stay IDLE, so back-to-back accepts are allowed.
- mov, cpy, nand, or, sll, srl, LUT, lt, eql, not (0100-1001, 1100-1111):
  - Next cycle: RegWrite with AluOut.
  - OverflowFlag unchanged.
- load (0010):
  - Next cycle: MemReq = 1, MemWrite = 0, MemAddr = AluOut; go to MEM_WAIT.
  - On the edge where MemAck = 1: MemReq <= 0, RegWrite <= 1 with RegWData = MemRData, return to IDLE.
  - Load-to-use latency is therefore ack cycle + 1.
- store (0011):
  - Next cycle: MemReq = 1, MemWrite = 1, MemAddr = AluOut, MemWData = StoreData; go to MEM_WAIT.
  - On MemAck: MemReq <= 0, return to IDLE, no RegWrite.
- rst (1010): OverflowFlag <= 0; no RegWrite; stay IDLE.
- halt (1011): Halted <= 1, go to HALTED. HALTED is absorbing until reset, InReady stays 0, and no further writes occur.
- MEM_WAIT rules:
  - MemReq, MemWrite, MemAddr and MemWData stay stable.
  - The timeout counter increments each cycle MemReq is high without ack.
  - When the counter reaches MEM_TIMEOUT: MemReq <= 0, MemError <= 1, no RegWrite, return to IDLE, counter cleared.
  - MemAck in the same cycle as the counter reaching its limit counts as success; ack wins.
- MemAck sampled while MemReq is low is ignored.
- RegWrite is a single-cycle pulse. RegWAddr/RegWData hold their last values when RegWrite is 0.
- Unlisted opcodes do not exist; all 16 encodings are covered above.

Test Plan:
- Reset, then add with AluOut = 8'hF0, AluOverflow = 1, DestReg = 2 -> next cycle RegWrite = 1, RegWData = F0, RegWAddr = 2, OverflowFlag = 1.
- Back-to-back: sub then or with InValid held high -> InReady stays 1; two consecutive RegWrite pulses with the correct data; OverflowFlag from sub is held through or.
- load AluOut = 8'h40, MemAck after 3 cycles with MemRData = 8'h5A -> MemReq high for 3 cycles at MemAddr = 40, then RegWrite with 5A; InReady = 0 throughout MEM_WAIT.
- store with MEM_TIMEOUT = 4 and no ack -> MemReq high for 4 cycles, then drops; MemError = 1; no RegWrite; InReady returns to 1.
- Flag set to 1 via add, then rst -> OverflowFlag = 0 next cycle; halt -> Halted = 1, InReady = 0, and subsequent InValid is ignored.
- ResetN pulsed low mid-load -> MemReq drops immediately, no RegWrite, all outputs 0; after release InReady = 1.
